// File: rtl/cnn16_pkg.sv
// Shared constants and state encoding for the cnn16 RAM arbiter.
// The loader, the CPU port and the load counter all use these.
package cnn16_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LD_MAX = 4096;

  typedef enum logic [2:0] {
    GAP     = 3'd0,
    LOAD    = 3'd1,
    READY   = 3'd2,
    CPU_WR  = 3'd3,
    CPU_RD1 = 3'd4,
    CPU_RD2 = 3'd5
  } arb_state_t;

endpackage

// File: rtl/cnn16_load_counter.sv
// Counts loader words in the current load session.
// The count saturates at LD_MAX instead of wrapping.
module cnn16_load_counter
  import cnn16_pkg::*;
#(
  parameter int CNT_W = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_W'(LD_MAX))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cnn16_mem_arbiter.sv
// Single-port arbiter for cnn16_ram, shared by the program loader and the CPU.
// It drains any in-flight CPU access before the loader takes the RAM port.
module cnn16_mem_arbiter
  import cnn16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err,
  output logic [2:0]        dbg_state
);

  // CPU handshake: cpu_req is accepted only in READY (mem_ready=1, ld_en=0);
  // the CPU holds cpu_req and its operands until the one-cycle cpu_ack pulse,
  // then drops cpu_req for at least one cycle.
  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata_hold;
  logic              r_mem_we;
  logic              r_mem_ready;
  logic              r_cpu_ack;
  logic              r_ld_err;

  logic              w_enter_load;
  logic              w_ld_inc;
  logic              w_ld_strobe_err;

  assign w_enter_load    = ld_en && (r_state inside {GAP, READY, CPU_WR, CPU_RD2});
  assign w_ld_inc        = (r_state == LOAD) && ld_we;
  assign w_ld_strobe_err = ld_we && r_mem_ready;

  cnn16_load_counter #(
    .CNT_W (ADDR_W + 1)
  ) u_load_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_enter_load),
    .inc   (w_ld_inc),
    .count (ld_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= GAP;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata_hold <= '0;
      r_mem_we     <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_ld_err     <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      if (w_ld_strobe_err) begin
        r_ld_err <= 1'b1;
      end
      case (r_state)
        GAP: begin
          if (ld_en) begin
            r_state <= LOAD;
          end else begin
            r_state     <= READY;
            r_mem_ready <= 1'b1;
          end
        end
        LOAD: begin
          // A strobe sampled together with ld_en falling is still written.
          r_mem_we    <= ld_we;
          r_mem_addr  <= ld_addr;
          r_mem_wdata <= ld_data;
          if (!ld_en) begin
            r_state <= GAP;
          end
        end
        READY: begin
          if (ld_en) begin
            r_state     <= LOAD;
            r_mem_ready <= 1'b0;
          end else if (cpu_req) begin
            r_mem_addr <= cpu_addr;
            if (cpu_we) begin
              r_mem_wdata <= cpu_wdata;
              r_mem_we    <= 1'b1;
              r_cpu_ack   <= 1'b1;
              r_state     <= CPU_WR;
            end else begin
              r_state <= CPU_RD1;
            end
          end
        end
        CPU_RD1: begin
          r_cpu_ack <= 1'b1;
          r_state   <= CPU_RD2;
        end
        CPU_WR, CPU_RD2: begin
          if (r_state == CPU_RD2) begin
            r_rdata_hold <= mem_rdata;
          end
          r_state     <= ld_en ? LOAD : READY;
          r_mem_ready <= !ld_en;
        end
        default: begin
          r_state     <= GAP;
          r_mem_ready <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_ready = r_mem_ready;
  assign cpu_ack   = r_cpu_ack;
  assign ld_err    = r_ld_err;
  assign dbg_state = r_state;
  // The RAM output is only valid during CPU_RD2, so it bypasses the hold register then.
  assign cpu_rdata = (r_state == CPU_RD2) ? mem_rdata : r_rdata_hold;

endmodule

// File: doc/cnn16_mem_arbiter.md
# cnn16_mem_arbiter

Single-port arbiter and sequencer for the `cnn16_ram` instance. It shares the RAM between the external program loader and the `cnn_top_module` CPU. It replaces the bare `sel_in` mux: it owns the RAM address/data/write-enable, generates the CPU's `mem_ready`, and makes mode switches safe by draining an in-flight CPU access before the loader takes the port.

## Interface
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 16, RAM data width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `ld_en`  in  1  loader mode request (1 = loader owns RAM)
- `ld_we`  in  1  loader write strobe, one word per cycle
- `ld_addr`  in  ADDR_W  loader write address
- `ld_data`  in  DATA_W  loader write data
- `cpu_req`  in  1  CPU access request, held until `cpu_ack`
- `cpu_we`  in  1  CPU access is a write
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `mem_rdata`  in  DATA_W  RAM `data_out`; synchronous read, valid 1 cycle after address
- `mem_addr`  out  ADDR_W  RAM address, registered
- `mem_wdata`  out  DATA_W  RAM write data, registered
- `mem_we`  out  1  RAM write enable, registered
- `mem_ready`  out  1  CPU may issue requests
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  read data, valid when `cpu_ack` is high after a read
- `ld_count`  out  ADDR_W+1  words written in the current load session, saturating at 4096
- `ld_err`  out  1  sticky: loader strobe arrived while `mem_ready` was 1

## Operation
- States: `GAP`, `LOAD`, `READY`, `CPU_WR`, `CPU_RD1`, `CPU_RD2`.
- `rst`=0 at an edge:
  - State becomes `GAP`.
  - All outputs become 0, including `ld_count` and `ld_err`.
- `GAP`: if `ld_en`, go to `LOAD`; otherwise go to `READY`. `mem_ready`=0.
- `LOAD`:
  - `mem_ready`=0.
  - Each cycle, `mem_we`/`mem_addr`/`mem_wdata` are registered from `ld_we`/`ld_addr`/`ld_data`.
  - Each `ld_we` increments `ld_count`; it saturates at 4096 and never wraps.
  - When `ld_en`=0, go to `GAP`. A `ld_we` sampled in that same cycle is still written.
- `READY`:
  - `mem_ready`=1.
  - Priority: `ld_en` > `cpu_req`. If `ld_en`, go to `LOAD`; `cpu_req` is not accepted.
  - Else if `cpu_req` and `cpu_we`: register addr/data with `mem_we`=1, then go to `CPU_WR`.
  - Else if `cpu_req` and not `cpu_we`: register addr with `mem_we`=0, then go to `CPU_RD1`.
- `CPU_WR`: `mem_we`=1 this cycle; `cpu_ack`=1. Next state is `LOAD` if `ld_en`, else `READY`.
- `CPU_RD1`: `mem_we`=0; the RAM samples the address. Go to `CPU_RD2`.
- `CPU_RD2`:
  - `cpu_ack`=1 and `cpu_rdata`=`mem_rdata`; `cpu_rdata` is registered into a hold register and held until the next read ack.
  - Next state is `LOAD` if `ld_en`, else `READY`.
- `ld_en` rising during `CPU_*`:
  - The CPU transaction completes with an ack and is never aborted.
  - `mem_ready` stays 1 until the transaction finishes, then falls.
- `ld_count` clears to 0 on every entry into `LOAD` from a non-`LOAD` state.
- `ld_we` outside `LOAD`:
  - It is ignored, and no RAM write occurs.
  - If `mem_ready`=1 at that time, `ld_err` is set. `ld_err` clears only on reset.
- `mem_we` is 0 in every state except `LOAD` with a strobe and `CPU_WR`.
- CPU rule: `cpu_req` must be low in the cycle after `cpu_ack`. A `cpu_req` seen high in `READY` is always a new transaction.

## Timing
- CPU write:
  - Request sampled at edge N.
  - `mem_we`=1 and `cpu_ack`=1 during cycle N+1; the RAM writes at edge N+2.
  - Throughput is 2 cycles per write.
- CPU read:
  - Request sampled at edge N.
  - `mem_addr` is valid in cycle N+1.
  - `cpu_ack` and `cpu_rdata` are valid in cycle N+2.
  - Throughput is 3 cycles per read.
- Loader write: strobe at edge N; `mem_we` in cycle N+1. Back-to-back strobes give 1 word/cycle.
- Mode switch load→CPU: `ld_en` falls, sampled at edge N → `GAP` → `READY` in cycle N+2.
- Mode switch CPU→load:
  - From `READY`: `LOAD` in the cycle after `ld_en` is sampled.
  - From `CPU_*`: `LOAD` immediately after the ack cycle.
- Reset mid-transaction: no ack is issued, and `mem_we` is 0 in the cycle after the reset edge.

## Structure
- Shared package `cnn16_pkg` holds:
  - `ADDR_W`, `DATA_W`
  - the `arb_state_t` enum (6 states above)
  - `LD_MAX` = 4096
- One sub-module, `cnn16_load_counter`:
  - Inputs: clear, increment, and saturating behaviour.
  - Outputs: `ld_count`.
- The FSM and output registers live in the top.

## Test plan
- Reset then load:
  - Stimulus: hold `rst`=0 for 2 cycles; then `ld_en`=1 and 4 strobes writing 0x1111…0x4444 at addresses 0x000–0x003.
  - Required: `mem_ready`=0 throughout, `mem_we` high for 4 consecutive cycles, `ld_count`=4.
- Switch to CPU then read back:
  - Stimulus: `ld_en`=0, then a CPU read of 0x002.
  - Required: `mem_ready` rises 2 cycles after `ld_en` falls; `cpu_ack` comes 2 cycles after request with `cpu_rdata`=0x3333.
- CPU write and readback:
  - Stimulus: write 0xBEEF to 0x010, then read 0x010.
  - Required: write ack in cycle N+1; read returns 0xBEEF.
- Load request during a CPU read:
  - Stimulus: raise `ld_en` in cycle `CPU_RD1`.
  - Required: read still acks with correct data; `LOAD` entered the next cycle; `ld_count` reset to 0.
- Protocol violation:
  - Stimulus: strobe `ld_we` while in `READY`.
  - Required: no `mem_we`, `ld_err`=1 and sticky until reset.
- Saturation:
  - Stimulus: 4097 strobes in one session.
  - Required: `ld_count`=4096, not 0.
